fifo_sync_flags: RTL and testbench



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 48 ++++
 rtl/fifo_sync_flags.sv | 96 +++++++++
 tb/tb_fifo_sync_flags.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its storage array.
package fifo_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one read port that is
// either registered (standard mode) or combinational (first-word-fall-through).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FWFT  = FWFT_OFF,
    parameter int AW    = clog2(DEFAULT_FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_async_read
            // The head word is gated by the caller; enable and reset have no role here.
            logic unused_ctrl;
            assign unused_ctrl = rd_en ^ rst;
            assign rd_data     = mem[rd_addr];
        end else begin : g_sync_read
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through mode.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AF_TH      = FIFO_DEPTH - 2,
    parameter int AE_TH      = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cs,
    input  logic                               wr_en,
    input  logic                               rd_en,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_empty,
    output logic                               almost_full,
    output logic [clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FIFO_DEPTH - 1);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // A write into a full FIFO is only allowed when a read frees a slot in the same cycle.
    assign rd_acc = cs & rd_en & ~empty;
    assign wr_acc = cs & wr_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CW'(1);
            end
            overflow  <= cs & wr_en & ~wr_acc;
            underflow <= cs & rd_en & ~rd_acc;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CW'(FIFO_DEPTH));
    assign almost_empty = (count <= CW'(AE_TH));
    assign almost_full  = (count >= CW'(AF_TH));

    fifo_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH),
        .FWFT  (FWFT),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft_out
            // Forcing zero while empty keeps the post-reset value deterministic.
            assign data_out = empty ? '0 : ram_rd_data;
        end else begin : g_std_out
            assign data_out = ram_rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed scoreboard bench for fifo_sync_flags in standard and first-word-fall-through modes.
module tb_fifo_sync_flags;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic        clk;
    logic        rst, cs, wr_en, rd_en;
    logic [31:0] data_in, data_out;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0]  count;

    logic        f_rst, f_cs, f_wr, f_rd;
    logic [31:0] f_din, f_dout;
    logic        f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [3:0]  f_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb [$];
    int          mcount;
    logic [31:0] mdout;

    fifo_sync_flags #(
        .FIFO_DEPTH (DEPTH), .DATA_WIDTH (32), .AF_TH (AF), .AE_TH (AE), .FWFT (0)
    ) dut (
        .clk (clk), .rst (rst), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
        .data_in (data_in), .data_out (data_out), .empty (empty), .full (full),
        .almost_empty (almost_empty), .almost_full (almost_full), .count (count),
        .overflow (overflow), .underflow (underflow)
    );

    fifo_sync_flags #(
        .FIFO_DEPTH (DEPTH), .DATA_WIDTH (32), .AF_TH (AF), .AE_TH (AE), .FWFT (1)
    ) dut_fwft (
        .clk (clk), .rst (f_rst), .cs (f_cs), .wr_en (f_wr), .rd_en (f_rd),
        .data_in (f_din), .data_out (f_dout), .empty (f_empty), .full (f_full),
        .almost_empty (f_ae), .almost_full (f_af), .count (f_count),
        .overflow (f_ovf), .underflow (f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output of the standard-mode instance against the queue model.
    task automatic checkAll(input string tag, input logic exp_ovf, input logic exp_udf);
        checkOutput({tag, " data_out"}, data_out, mdout);
        checkOutput({tag, " count"}, 32'(count), 32'(mcount));
        checkOutput({tag, " empty"}, 32'(empty), 32'(mcount == 0));
        checkOutput({tag, " full"}, 32'(full), 32'(mcount == DEPTH));
        checkOutput({tag, " almost_empty"}, 32'(almost_empty), 32'(mcount <= AE));
        checkOutput({tag, " almost_full"}, 32'(almost_full), 32'(mcount >= AF));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        checkOutput({tag, " underflow"}, 32'(underflow), 32'(exp_udf));
    endtask

    task automatic applyStimulus(input string tag, input logic c, input logic w, input logic r,
                                 input logic [31:0] d);
        logic rd_ok, wr_ok;
        rd_ok   = c && r && (mcount > 0);
        wr_ok   = c && w && ((mcount < DEPTH) || rd_ok);
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        if (rd_ok) mdout = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        mcount = sb.size();
        cs     = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        checkAll(tag, c && w && !wr_ok, c && r && !rd_ok);
    endtask

    task automatic applyReset();
        rst   = 1'b1;
        cs    = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mcount = 0;
        mdout  = '0;
        checkAll("reset", 1'b0, 1'b0);
    endtask

    task automatic applyFwft(input logic r_in, input logic w, input logic r, input logic [31:0] d);
        f_rst = r_in;
        f_cs  = 1'b1;
        f_wr  = w;
        f_rd  = r;
        f_din = d;
        @(posedge clk);
        #1;
        f_rst = 1'b0;
        f_wr  = 1'b0;
        f_rd  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        f_rst = 1'b0; f_cs = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
        mcount = 0;
        mdout  = '0;
        $display("[TB] start");

        // Test 1: three writes then three reads.
        applyReset();
        applyStimulus("cs_low", 1'b0, 1'b1, 1'b1, 32'h55);
        applyStimulus("t1_wr", 1'b1, 1'b1, 1'b0, 32'd1);
        applyStimulus("t1_wr", 1'b1, 1'b1, 1'b0, 32'd10);
        applyStimulus("t1_wr", 1'b1, 1'b1, 1'b0, 32'd100);
        for (int i = 0; i < 3; i++) applyStimulus("t1_rd", 1'b1, 1'b0, 1'b1, 32'h0);

        // Test 2: nine writes of powers of two; the last overflows.
        for (int i = 0; i < 9; i++) applyStimulus("t2_wr", 1'b1, 1'b1, 1'b0, 32'(1) << i);
        applyStimulus("t2_idle", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus("t2_rd", 1'b1, 1'b0, 1'b1, 32'h0);

        // Test 3: simultaneous read/write while full, crossing the pointer wrap.
        for (int i = 0; i < 8; i++) applyStimulus("t3_fill", 1'b1, 1'b1, 1'b0, 32'(1) << i);
        for (int i = 0; i < 3; i++) applyStimulus("t3_rw", 1'b1, 1'b1, 1'b1, 32'hAA);
        for (int i = 0; i < 8; i++) applyStimulus("t3_rd", 1'b1, 1'b0, 1'b1, 32'h0);

        // Test 4: read on empty combined with a write.
        applyStimulus("t4_rw_empty", 1'b1, 1'b1, 1'b1, 32'd5);
        applyStimulus("t4_rd", 1'b1, 1'b0, 1'b1, 32'h0);
        applyStimulus("t4_rd_empty", 1'b1, 1'b0, 1'b1, 32'h0);

        // Test 5: threshold walk up and down.
        for (int i = 0; i < 8; i++) applyStimulus("t5_up", 1'b1, 1'b1, 1'b0, 32'(i + 32'h100));
        for (int i = 0; i < 8; i++) applyStimulus("t5_dn", 1'b1, 1'b0, 1'b1, 32'h0);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 3; i++) applyStimulus("mid_fill", 1'b1, 1'b1, 1'b0, 32'(i + 32'h200));
        applyReset();
        applyStimulus("post_rst_rd", 1'b1, 1'b0, 1'b1, 32'h0);

        // Test 6: first-word-fall-through instance.
        applyFwft(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("f_reset empty", 32'(f_empty), 32'd1);
        checkOutput("f_reset count", 32'(f_count), 32'd0);
        applyFwft(1'b0, 1'b1, 1'b0, 32'd7);
        checkOutput("f_wr7 data_out", f_dout, 32'd7);
        checkOutput("f_wr7 count", 32'(f_count), 32'd1);
        applyFwft(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("f_idle data_out", f_dout, 32'd7);
        applyFwft(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("f_pop empty", 32'(f_empty), 32'd1);
        checkOutput("f_pop count", 32'(f_count), 32'd0);
        for (int i = 0; i < 5; i++) applyFwft(1'b0, 1'b1, 1'b0, 32'(i + 11));
        checkOutput("f_fill data_out", f_dout, 32'd11);
        checkOutput("f_fill count", 32'(f_count), 32'd5);
        applyFwft(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("f_pop2 data_out", f_dout, 32'd12);
        checkOutput("f_pop2 count", 32'(f_count), 32'd4);
        applyFwft(1'b0, 1'b1, 1'b0, 32'd16);
        checkOutput("f_refill count", 32'(f_count), 32'd5);
        applyFwft(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("f_rst count", 32'(f_count), 32'd0);
        checkOutput("f_rst empty", 32'(f_empty), 32'd1);
        checkOutput("f_rst data_out", f_dout, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
